// File: rtl/led_column_streamer_if.sv
// led_column_streamer_if: encoder step input, image RAM read port and APA102 strip outputs
interface led_column_streamer_if #(
   parameter int NUM_LEDS = 8,
   parameter int NUM_COLS = 32
);
   localparam int AW = $clog2(NUM_COLS * NUM_LEDS);
   localparam int CW = $clog2(NUM_COLS);
   logic step;
   logic dir;
   logic [AW-1:0] mem_addr;
   logic [23:0] mem_data;
   logic led_sck;
   logic led_sdo;
   logic [CW-1:0] col;
   logic busy;
   logic frame_done;
   logic overrun;
   modport master (
      input step, dir, mem_data,
      output mem_addr, led_sck, led_sdo, col, busy, frame_done, overrun
   );
   modport slave (
      output step, dir, mem_data,
      input mem_addr, led_sck, led_sdo, col, busy, frame_done, overrun
   );
endinterface

// File: rtl/led_column_streamer.sv
// led_column_streamer: tracks an encoder column pointer and streams that column as one APA102 frame
module led_column_streamer #(
   parameter int NUM_LEDS = 8,
   parameter int NUM_COLS = 32,
   parameter int CLK_DIV = 4,
   parameter logic [4:0] BRIGHT = 5'd31
) (
   input logic clk,
   input logic reset,
   led_column_streamer_if.master bus
);
   localparam int AW = $clog2(NUM_COLS * NUM_LEDS);
   localparam int CW = $clog2(NUM_COLS);
   localparam int PW = $clog2(2 * CLK_DIV);
   localparam logic [PW-1:0] PH_LAST = PW'(2 * CLK_DIV - 1);
   localparam logic [6:0] LAST_LED = 7'(NUM_LEDS - 1);
   typedef enum logic [2:0] {IDLE, START, FETCH_A, FETCH_L, PIXEL, END} state_t;
   state_t state_q, state_d;
   logic [CW-1:0] col_q, col_d, fcol_q, fcol_d;
   logic [6:0] idx_q, idx_d;
   logic [PW-1:0] ph_q, ph_d;
   logic [4:0] bit_q, bit_d;
   logic [31:0] sr_q, sr_d, load_word;
   logic [AW-1:0] addr_q, addr_d;
   logic sck_q, sck_d, sdo_q, sdo_d, busy_q, busy_d, done_q, done_d;
   logic ovr_q, ovr_d, pend_q, pend_d;
   logic bit_end, word_end, step_busy, load, to_fetch;
   always_comb begin
      col_d = !bus.step ? col_q
            : bus.dir ? (col_q == CW'(NUM_COLS - 1) ? '0 : col_q + 1'b1)
            : (col_q == '0 ? CW'(NUM_COLS - 1) : col_q - 1'b1);
      bit_end = ph_q == PH_LAST;
      word_end = bit_end && bit_q == 5'd31;
      step_busy = bus.step && state_q != IDLE;
      state_d = state_q;
      fcol_d = fcol_q;
      pend_d = pend_q || step_busy;
      ovr_d = ovr_q || (step_busy && pend_q);
      load = 1'b0;
      load_word = '0;
      to_fetch = 1'b0;
      ph_d = ph_q;
      sck_d = sck_q;
      bit_d = bit_q;
      sr_d = sr_q;
      sdo_d = sdo_q;
      // sck is low for the first CLK_DIV cycles of a bit, high for the rest
      if (state_q inside {START, PIXEL, END}) begin
         ph_d = bit_end ? '0 : ph_q + 1'b1;
         sck_d = !bit_end && 32'(ph_q) >= CLK_DIV - 1;
         bit_d = bit_end ? bit_q + 5'd1 : bit_q;
         sr_d = bit_end ? sr_q << 1 : sr_q;
         sdo_d = bit_end && !word_end ? sr_q[30] : sdo_q;
      end
      case (state_q)
         IDLE: if (bus.step) begin
            state_d = START;
            fcol_d = col_d;
            load = 1'b1;
         end
         START: if (word_end) begin
            state_d = FETCH_A;
            to_fetch = 1'b1;
         end
         FETCH_A: state_d = FETCH_L;
         FETCH_L: begin
            state_d = PIXEL;
            load = 1'b1;
            load_word = {3'b111, BRIGHT, bus.mem_data[7:0], bus.mem_data[15:8], bus.mem_data[23:16]};
         end
         PIXEL: if (word_end) begin
            state_d = idx_q == LAST_LED ? END : FETCH_A;
            to_fetch = idx_q != LAST_LED;
            load = idx_q == LAST_LED;
            load_word = '1;
         end
         END: if (word_end) begin
            state_d = pend_d ? START : IDLE;
            fcol_d = pend_d ? col_d : fcol_q;
            load = pend_d;
            pend_d = 1'b0;
         end
         default: state_d = IDLE;
      endcase
      idx_d = to_fetch ? (state_q == START ? 7'd0 : idx_q + 7'd1) : idx_q;
      addr_d = to_fetch ? AW'(32'(fcol_q) * 32'(NUM_LEDS) + 32'(idx_d)) : addr_q;
      if (load) begin
         sr_d = load_word;
         sdo_d = load_word[31];
         ph_d = '0;
         bit_d = '0;
         sck_d = 1'b0;
      end
      busy_d = state_d != IDLE;
      done_d = state_d == END && bit_d == 5'd31 && ph_d == PH_LAST;
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         col_q <= '0;
         fcol_q <= '0;
         idx_q <= '0;
         ph_q <= '0;
         bit_q <= '0;
         sr_q <= '0;
         addr_q <= '0;
         sck_q <= 1'b0;
         sdo_q <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         ovr_q <= 1'b0;
         pend_q <= 1'b0;
      end else begin
         state_q <= state_d;
         col_q <= col_d;
         fcol_q <= fcol_d;
         idx_q <= idx_d;
         ph_q <= ph_d;
         bit_q <= bit_d;
         sr_q <= sr_d;
         addr_q <= addr_d;
         sck_q <= sck_d;
         sdo_q <= sdo_d;
         busy_q <= busy_d;
         done_q <= done_d;
         ovr_q <= ovr_d;
         pend_q <= pend_d;
      end
   end
   assign bus.mem_addr = addr_q;
   assign bus.led_sck = sck_q;
   assign bus.led_sdo = sdo_q;
   assign bus.col = col_q;
   assign bus.busy = busy_q;
   assign bus.frame_done = done_q;
   assign bus.overrun = ovr_q;
endmodule

// File: tb/tb_led_column_streamer.sv
// tb_led_column_streamer: random/directed steps checked against a frame-timing and bitstream model
module tb_led_column_streamer;
   localparam int NUM_LEDS = 8;
   localparam int NUM_COLS = 32;
   localparam int CLK_DIV = 4;
   localparam int L = 2 * CLK_DIV * 32 * (NUM_LEDS + 2) + 2 * NUM_LEDS;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int checks = 0;
   int errors = 0;
   always #5 clk = ~clk;
   led_column_streamer_if #(.NUM_LEDS(NUM_LEDS), .NUM_COLS(NUM_COLS)) bus();
   led_column_streamer #(.NUM_LEDS(NUM_LEDS), .NUM_COLS(NUM_COLS), .CLK_DIV(CLK_DIV), .BRIGHT(5'd31)) dut (
      .clk(clk), .reset(reset), .bus(bus));
   led_column_streamer_if #(.NUM_LEDS(1), .NUM_COLS(4)) b1();
   led_column_streamer #(.NUM_LEDS(1), .NUM_COLS(4), .CLK_DIV(1), .BRIGHT(5'd31)) u1 (
      .clk(clk), .reset(reset), .bus(b1));
   logic [23:0] ram [256];
   logic [23:0] ram1 [4];
   always @(posedge clk) bus.mem_data <= ram[bus.mem_addr];
   always @(posedge clk) b1.mem_data <= ram1[b1.mem_addr];
   // model: frames occupy L cycles from the cycle after their trigger
   int cyc = 0;
   bit active = 0;
   bit pend = 0;
   bit m_ovr = 0;
   int f_end = 0;
   int m_col = 0;
   int exp_q[$];
   logic got[$];
   logic prev_sck = 1'b0;
   logic [31:0] w1_last;
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   function automatic logic [31:0] qword(input logic q[$], input int w);
      logic [31:0] r;
      for (int b = 0; b < 32; b++) r[31-b] = (w * 32 + b < q.size()) ? q[w*32+b] : 1'bx;
      return r;
   endfunction
   function automatic logic [31:0] pix(input logic [23:0] p);
      return {3'b111, 5'd31, p[7:0], p[15:8], p[23:16]};
   endfunction
   task automatic check_frame();
      int fc;
      logic [31:0] ew;
      logic [31:0] gw;
      fc = exp_q.size() > 0 ? exp_q.pop_front() : 0;
      chk("frame_bits", 64'(got.size()), 64'(32 * (NUM_LEDS + 2)));
      for (int w = 0; w < NUM_LEDS + 2; w++) begin
         ew = w == 0 ? 32'h0 : w == NUM_LEDS + 1 ? 32'hFFFF_FFFF : pix(ram[fc * NUM_LEDS + w - 1]);
         gw = qword(got, w);
         if (w == 1) w1_last = gw;
         chk("frame_word", {32'(w), gw}, {32'(w), ew});
      end
      got.delete();
   endtask
   task automatic tick(input logic s, input logic d);
      bit busy_c;
      bit exp_done;
      bus.step = s;
      bus.dir = d;
      @(posedge clk);
      busy_c = active;
      if (s) m_col = d ? (m_col + 1) % NUM_COLS : (m_col + NUM_COLS - 1) % NUM_COLS;
      if (s && busy_c) begin
         if (pend) m_ovr = 1;
         pend = 1;
      end
      if (busy_c && cyc == f_end) begin
         if (pend) begin
            pend = 0;
            f_end = cyc + L;
            exp_q.push_back(m_col);
         end else active = 0;
      end
      if (s && !busy_c) begin
         active = 1;
         f_end = cyc + L;
         exp_q.push_back(m_col);
      end
      cyc++;
      exp_done = active && cyc == f_end;
      #1;
      if (bus.led_sck && !prev_sck) got.push_back(bus.led_sdo);
      prev_sck = bus.led_sck;
      chk("busy", 64'(bus.busy), 64'(active));
      chk("frame_done", 64'(bus.frame_done), 64'(exp_done));
      chk("col", 64'(bus.col), 64'(m_col));
      chk("overrun", 64'(bus.overrun), 64'(m_ovr));
      if (!active) chk("sck_idle", 64'(bus.led_sck), 64'(0));
      if (exp_done) check_frame();
      bus.step = 1'b0;
   endtask
   task automatic do_reset(input logic s);
      reset = 1'b0;
      bus.step = s;
      bus.dir = 1'b1;
      @(posedge clk);
      #1;
      active = 0;
      pend = 0;
      m_ovr = 0;
      m_col = 0;
      cyc++;
      exp_q.delete();
      got.delete();
      prev_sck = 1'b0;
      chk("rst_sck", 64'(bus.led_sck), 64'(0));
      chk("rst_sdo", 64'(bus.led_sdo), 64'(0));
      chk("rst_busy", 64'(bus.busy), 64'(0));
      chk("rst_col", 64'(bus.col), 64'(0));
      chk("rst_addr", 64'(bus.mem_addr), 64'(0));
      chk("rst_done", 64'(bus.frame_done), 64'(0));
      chk("rst_ovr", 64'(bus.overrun), 64'(0));
      bus.step = 1'b0;
      reset = 1'b1;
   endtask
   task automatic run_idle();
      int n = 0;
      while (active && n < 3 * L) begin
         tick(1'b0, 1'b0);
         n++;
      end
      tick(1'b0, 1'b0);
   endtask
   initial begin
      int n;
      logic got1[$];
      logic p1;
      bus.step = 1'b0;
      bus.dir = 1'b0;
      b1.step = 1'b0;
      b1.dir = 1'b0;
      for (int i = 0; i < 256; i++) ram[i] = 24'($urandom);
      for (int i = 0; i < 4; i++) ram1[i] = 24'($urandom);
      ram[248] = 24'hFF0000;
      repeat (2) @(posedge clk);
      do_reset(1'b0);
      tick(1'b1, 1'b1);
      run_idle();
      do_reset(1'b0);
      tick(1'b1, 1'b0);
      run_idle();
      chk("red_word", 64'(w1_last), 64'h0000_0000_FF00_00FF);
      do_reset(1'b0);
      tick(1'b1, 1'b1);
      repeat (99) tick(1'b0, 1'b0);
      tick(1'b1, 1'b1);
      run_idle();
      do_reset(1'b0);
      tick(1'b1, 1'b1);
      repeat (300) tick(1'b0, 1'b0);
      tick(1'b1, 1'b0);
      repeat (300) tick(1'b0, 1'b0);
      tick(1'b1, 1'b0);
      tick(1'b1, 1'b0);
      run_idle();
      tick(1'b1, 1'b1);
      run_idle();
      do_reset(1'b0);
      tick(1'b1, 1'b1);
      repeat (499) tick(1'b0, 1'b0);
      do_reset(1'b1);
      repeat (50) tick(1'b0, 1'b0);
      tick(1'b1, 1'b1);
      repeat (L - 1) tick(1'b0, 1'b0);
      tick(1'b1, 1'b1);
      run_idle();
      do_reset(1'b0);
      for (int i = 0; i < 6000; i++) tick(1'($urandom_range(0, 399) == 0), 1'($urandom_range(0, 1)));
      run_idle();
      do_reset(1'b0);
      b1.dir = 1'b1;
      b1.step = 1'b1;
      @(posedge clk);
      #1;
      b1.step = 1'b0;
      n = 1;
      p1 = 1'b0;
      while (n < 1000) begin
         if (b1.led_sck && !p1) got1.push_back(b1.led_sdo);
         p1 = b1.led_sck;
         if (b1.frame_done) break;
         @(posedge clk);
         #1;
         n++;
      end
      chk("small_len", 64'(n), 64'(194));
      chk("small_rises", 64'(got1.size()), 64'(96));
      chk("small_w0", 64'(qword(got1, 0)), 64'(0));
      chk("small_w1", 64'(qword(got1, 1)), 64'(pix(ram1[1])));
      chk("small_w2", 64'(qword(got1, 2)), 64'hFFFF_FFFF);
      @(posedge clk);
      #1;
      chk("small_busy_after", 64'(b1.busy), 64'(0));
      chk("small_col", 64'(b1.col), 64'(1));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/led_column_streamer.md
# led_column_streamer

Downstream stage of the quadrature encoder decoder. Consumes the decoder's one-cycle step pulse and direction, and keeps a wrapping column pointer into the image buffer. For each column change it fetches that column's pixels from a synchronous RAM and serializes one complete APA102 frame (start frame, one word per LED, end frame) onto the LED strip's two-wire SPI.

## Interface
Parameters:
- NUM_LEDS, 8: pixels per column (LEDs on strip), 1..64
- NUM_COLS, 32: columns in image buffer, power of two not required, ≥2
- CLK_DIV, 4: clk cycles per SCK half-period, ≥1
- BRIGHT, 5'd31: global 5-bit brightness field placed in every LED word

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset (sampled on rising clk edge)
- step  in  1  one-cycle pulse: encoder advanced one detent
- dir  in  1  sampled with step; 1 = forward (increment), 0 = backward
- mem_addr  out  $clog2(NUM_COLS*NUM_LEDS)  image RAM read address
- mem_data  in  24  pixel {R[23:16],G[15:8],B[7:0]}, valid 1 cycle after mem_addr
- led_sck  out  1  strip SPI clock, idles low
- led_sdo  out  1  strip SPI data, MSB first
- col  out  $clog2(NUM_COLS)  current column pointer
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse at end of each frame
- overrun  out  1  sticky: a step was lost (cleared only by reset)

## Operation
- Reset (reset==0 at clk edge): state IDLE; col=0, mem_addr=0, led_sck=0, led_sdo=0, busy=0, frame_done=0, overrun=0, pending=0. Applies mid-frame; no partial bits continue.
- Column pointer: on step, col ← dir ? (col==NUM_COLS-1 ? 0 : col+1) : (col==0 ? NUM_COLS-1 : col-1). The pointer updates on every step, regardless of state.
- Frame column latched into fcol at frame start; later steps never alter an in-flight frame.
- step in IDLE → enter START next cycle with fcol = updated col.
- step while busy: if pending==0 set pending; else set overrun (step coalesced, pointer still moves).
- States:
  - IDLE → START.
  - START: shift 32 zero bits → FETCH_A, led index i=0.
  - FETCH_A: drive mem_addr = fcol*NUM_LEDS + i → FETCH_L.
  - FETCH_L: load shift reg {3'b111, BRIGHT, B, G, R} from mem_data → PIXEL.
  - PIXEL: shift 32 bits → FETCH_A with i+1, or END if i==NUM_LEDS-1.
  - END: shift 32 one bits → IDLE, or START if pending (then pending cleared, fcol = current col).
- Bit shifting: led_sdo set while led_sck low; led_sck low CLK_DIV cycles then high CLK_DIV cycles per bit; strip samples on rising edge. led_sck held low and led_sdo held at last value during FETCH_A/FETCH_L.
- mem_addr holds last value outside FETCH_A.

## Timing
- step at cycle 0 in IDLE: busy=1 and first bit on led_sdo at cycle 1; first led_sck rise at cycle 1+CLK_DIV.
- Bit period 2*CLK_DIV cycles. Frame length L = 2*CLK_DIV*32*(NUM_LEDS+2) + 2*NUM_LEDS cycles (defaults: 2576).
- frame_done pulses in the last cycle of END (cycle L for a cycle-0 start). busy drops the cycle after, unless pending restarts START immediately (busy stays 1, no idle gap).
- step coincident with last END cycle: counts as step while busy (sets pending or overrun); a restart occurs.
- step and reset same cycle: reset wins.
- mem_data is captured exactly one cycle after mem_addr is driven.

## Test plan
- Reset, then step dir=1: col=1, mem_addr sequence 8..15, SDO frame = 32×0, 8×{111,11111,B,G,R}, 32×1; frame_done at cycle 2576, busy low at 2577.
- From col=0, step dir=0: col=31, mem_addrs 248..255; RAM word 0xFF0000 at 248 yields 0xFF0000FF on the strip (brightness 31, B=0, G=0, R=FF).
- Two steps 100 cycles apart, both dir=1: second frame starts the cycle after frame_done with fcol=2. busy never drops. overrun=0.
- Three steps during one frame: overrun=1 and stays 1 through later frames. Exactly one extra frame uses the final col.
- reset asserted at cycle 500 of a frame: next cycle sck=0, sdo=0, busy=0, col=0, no further sck edges.
- CLK_DIV=1, NUM_LEDS=1: sck toggles every cycle. Frame length 2*32*3+2=194 cycles.
